bias_ram_loader: RTL and testbench
==================================

# bias_ram_loader

Write-side front end for the bias storage: accepts a stream of 18-bit bias words and scatters them across the six single-port bias RAM banks that the accumulator reads in parallel. Words arrive lane-major within a row (lane 0..5 of row r, then row r+1) and are converted into per-bank write strobes with a shared address and data bus. Sits between the host/DMA bias stream and the six bias RAM write ports; the read path stays unchanged, and the accumulator must not read while `busy` is high.

## Interface
- `LANES`, 6, number of bias banks (one-hot write-enable width)
- `DW`, 18, bias word width
- `AW`, 9, bank address width (512 rows)
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `start` input 1 — one-cycle pulse; begins a load, ignored when `busy`
- `base_addr` input AW — first row address, sampled on accepted `start`
- `num_rows` input AW+1 — rows to load, 0..512, sampled on accepted `start`
- `abort` input 1 — terminates an active load
- `s_valid` input 1 — stream word valid
- `s_data` input DW — stream word
- `s_ready` output 1 — loader accepts word this cycle
- `wr_addr` output AW — bank write address (registered)
- `wr_data` output DW — bank write data (registered)
- `wr_en` output LANES — one-hot bank write enable (registered)
- `busy` output 1 — load in progress
- `done` output 1 — one-cycle pulse on normal completion
- `err` output 1 — sticky; set by abort, cleared by next accepted `start`

## Operation
- FSM states: IDLE, LOAD, FIN.
- IDLE: `start` latches `base_addr`/`num_rows`, clears lane/row counters and `err`. Goes to LOAD when `num_rows` != 0, otherwise to FIN.
- LOAD: `s_ready`=1. A handshake (`s_valid`&&`s_ready`) writes `s_data` to bank `lane` at `base_addr+row` (mod 512, wraps silently).
- Lane counter 0..LANES-1. On the LANES-1 handshake, lane returns to 0 and row increments.
- Handshake at row==`num_rows`-1 and lane==LANES-1 → FIN.
- FIN: `done`=1 for one cycle → IDLE.
- `abort` in LOAD or FIN → IDLE. No `done`; `err`=1. A handshake in the same cycle as `abort` is dropped (no write).
- `start` in the same cycle as the final handshake is ignored.
- `busy`=1 in LOAD and FIN.

## Timing
- Reset values: `s_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0, state IDLE, counters 0.
- `s_ready` is a registered state decode, not combinational from `s_valid`. It rises the cycle after the accepted `start` and falls the cycle after the final handshake.
- Write latency is 1 cycle: a handshake at cycle t drives `wr_en`/`wr_addr`/`wr_data` during cycle t+1. `wr_en`=0 on all other cycles.
- `done` is asserted in the cycle after the last write strobe.
- Throughput is one word per cycle; a full 512-row load takes 3072 accepting cycles.
- Reset mid-load: all state clears immediately; a partially written bank keeps its contents.

## Configuration
- `BIAS_LOAD_CSUM_EN` defined:
  - Adds output `csum` [DW-1:0], the sum mod 2^18 of all accepted words.
  - Cleared on accepted `start`; stable from the `done` pulse until the next `start`.
  - Reset value 0.
- Undefined: port and adder absent; all other behaviour is identical.

## Structure
- Shared package `bias_pkg`: `BIAS_LANES`, `BIAS_DW`, `BIAS_AW` constants and the `bias_load_state_t` enum (IDLE/LOAD/FIN). The accumulator's read wrapper shares the same constants.
- One sub-module, `bias_wr_cnt`: the lane/row counter pair with wrap and last-word flag. The FSM and output registers stay in the top.

## Test plan
- `base_addr`=0, `num_rows`=2, 12 back-to-back words 1..12 → `wr_en` 000001..100000 at addr 0, then again at addr 1; `done` one cycle after the 12th strobe.
- `base_addr`=511, `num_rows`=2 → row 0 written at addr 511, row 1 at addr 0 (wrap); `done` pulses once.
- `num_rows`=0 → no `wr_en`, `s_ready` stays 0; `done` 2 cycles after `start`.
- `s_valid` toggled randomly over a 3-row load → exactly 18 strobes in order; no write on any cycle without a handshake.
- `abort` asserted after 7 words, coincident with the 8th handshake → 7 strobes, no `done`, `err`=1; next `start` clears `err`.
- With `BIAS_LOAD_CSUM_EN`, 6 words of 0x3FFFF → `csum`=0x3FFFA at `done`.

Source files
------------

// File: rtl/bias_pkg.sv
// Shared bias-storage constants and loader state type; the accumulator's read
// wrapper imports the same constants so both sides agree on bank geometry.
package bias_pkg;

    localparam int BIAS_LANES = 6;
    localparam int BIAS_DW    = 18;
    localparam int BIAS_AW    = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } bias_load_state_t;

endpackage

// File: rtl/bias_wr_cnt.sv
// Lane/row position of the next stream word within a bias load, plus a flag
// marking the final word of the load.
module bias_wr_cnt
    import bias_pkg::*;
#(
    parameter int LANES = BIAS_LANES,
    parameter int AW    = BIAS_AW,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    input  logic [AW:0]   num_rows,
    output logic [LW-1:0] lane,
    output logic [AW-1:0] row,
    output logic          last
);

    logic lane_wrap;

    assign lane_wrap = (lane == LW'(LANES - 1));
    assign last      = lane_wrap && ({1'b0, row} == (num_rows - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            row  <= '0;
        end else if (clear) begin
            lane <= '0;
            row  <= '0;
        end else if (advance) begin
            if (lane_wrap) begin
                lane <= '0;
                row  <= row + 1'b1;
            end else begin
                lane <= lane + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bias_ram_loader.sv
// Scatters a lane-major bias word stream into one-hot bank write strobes.
// Optional BIAS_LOAD_CSUM_EN adds a running checksum output of accepted words.
module bias_ram_loader
    import bias_pkg::*;
#(
    parameter int LANES = BIAS_LANES,
    parameter int DW    = BIAS_DW,
    parameter int AW    = BIAS_AW,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      num_rows,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    output logic             s_ready,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    wr_data,
    output logic [LANES-1:0] wr_en,
    output logic             busy,
    output logic             done,
`ifdef BIAS_LOAD_CSUM_EN
    output logic [DW-1:0]    csum,
`endif
    output logic             err
);

    bias_load_state_t state, state_nxt;

    logic [AW-1:0] base_q;
    logic [AW:0]   rows_q;
    logic [LW-1:0] lane;
    logic [AW-1:0] row;
    logic          last;
    logic          start_ok;
    logic          hs;

    assign start_ok = start && (state == IDLE);
    // A word offered in the abort cycle is dropped, so abort masks the handshake.
    assign hs       = s_valid && s_ready && !abort;

    bias_wr_cnt #(
        .LANES (LANES),
        .AW    (AW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok),
        .advance  (hs),
        .num_rows (rows_q),
        .lane     (lane),
        .row      (row),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_rows != '0) ? LOAD : FIN;
            LOAD: begin
                if (abort)          state_nxt = IDLE;
                else if (hs && last) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == LOAD);
        busy    = (state != IDLE);
    end

    // done trails FIN by a register so it lands one cycle after the last strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            base_q  <= '0;
            rows_q  <= '0;
        end else begin
            wr_en <= '0;
            done  <= (state == FIN) && !abort;
            if (hs) begin
                wr_en   <= LANES'(1) << lane;
                wr_addr <= base_q + row;
                wr_data <= s_data;
            end
            if (start_ok) begin
                base_q <= base_addr;
                rows_q <= num_rows;
                err    <= 1'b0;
            end else if (abort && (state != IDLE)) begin
                err <= 1'b1;
            end
        end
    end

`ifdef BIAS_LOAD_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        csum <= '0;
        else if (start_ok) csum <= '0;
        else if (hs)       csum <= csum + s_data;
    end
`endif

endmodule

// File: tb/tb_bias_ram_loader.sv
// Randomized directed bench for bias_ram_loader against a word-index model of
// where each accepted word must land; checks BIAS_LOAD_CSUM_EN when defined.
module tb_bias_ram_loader;
    import bias_pkg::*;

    localparam int LANES = BIAS_LANES;
    localparam int DW    = BIAS_DW;
    localparam int AW    = BIAS_AW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [AW:0]      num_rows = '0;
    logic             abort = 1'b0;
    logic             s_valid = 1'b0;
    logic [DW-1:0]    s_data = '0;
    logic             s_ready;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [LANES-1:0] wr_en;
    logic             busy;
    logic             done;
    logic             err;
`ifdef BIAS_LOAD_CSUM_EN
    logic [DW-1:0]    csum;
`endif

    always #5 clk = ~clk;

    bias_ram_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
`ifdef BIAS_LOAD_CSUM_EN
        .csum      (csum),
`endif
        .err       (err)
    );

    typedef struct packed {
        logic [31:0]      cyc;
        logic [LANES-1:0] en;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
    } wr_rec_t;

    wr_rec_t     obs_wr[$];
    wr_rec_t     exp_wr[$];
    int unsigned obs_done[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe and done pulse is logged with the cycle it was seen in.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en != '0) obs_wr.push_back('{cyc, wr_en, wr_addr, wr_data});
            if (done) obs_done.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [95:0] observed,
                               input logic [95:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One load: model says word k goes to lane k%LANES at (base + k/LANES) mod 2^AW.
    task automatic applyStimulus(input logic [AW-1:0] base, input int rows,
                                 input int valid_pct, input int abort_after,
                                 input int data_mode, input string name);
        int          total_words;
        int          accepted;
        int          ready_bad;
        int          guard;
        bit          aborted;
        bit          finished;
        int unsigned last_cyc;
        int unsigned start_cyc;
        logic [DW-1:0] word;
        logic [DW-1:0] sum;
        wr_rec_t     rec;

        total_words = rows * LANES;
        accepted = 0; ready_bad = 0; guard = 0;
        aborted = 0; last_cyc = 0; sum = '0;
        finished = (rows == 0);
        obs_wr.delete(); obs_done.delete(); exp_wr.delete();
        $display("[TB] load %s base=%0d rows=%0d", name, base, rows);

        @(posedge clk); #1;
        start = 1'b1; base_addr = base; num_rows = (AW+1)'(rows);
        s_valid = 1'b0; abort = 1'b0; start_cyc = cyc;
        @(negedge clk);
        checkOutput({name, "_ready_before"}, 96'(s_ready), 96'(0));
        @(posedge clk); #1;
        start = 1'b0;

        if (rows == 0) begin
            @(negedge clk);
            checkOutput({name, "_busy_fin"}, 96'(busy), 96'(1));
            checkOutput({name, "_ready_zero"}, 96'(s_ready), 96'(0));
            @(posedge clk); #1;
        end

        while (!finished && !aborted && guard < 20000) begin
            guard++;
            s_valid = ($urandom_range(99) < valid_pct);
            word = (data_mode == 0) ? DW'($urandom) :
                   (data_mode == 1) ? DW'(accepted + 1) : '1;
            s_data = word;
            start = ($urandom_range(7) == 0);
            base_addr = AW'($urandom);
            abort = (abort_after >= 0) && (accepted == abort_after) && s_valid;
            @(negedge clk);
            if (guard == 1) checkOutput({name, "_err_cleared"}, 96'(err), 96'(0));
            if (s_ready !== 1'b1 || busy !== 1'b1) ready_bad++;
            if (abort) begin
                aborted = 1;
            end else if (s_valid) begin
                rec.cyc  = cyc + 1;
                rec.en   = LANES'(1 << (accepted % LANES));
                rec.addr = AW'((int'(base) + accepted / LANES) % (1 << AW));
                rec.data = word;
                exp_wr.push_back(rec);
                sum = sum + word;
                accepted++;
                if (accepted == total_words) begin
                    finished = 1;
                    last_cyc = cyc;
                end
            end
            @(posedge clk); #1;
        end

        s_valid = 1'b0; abort = 1'b0; start = 1'b0;
        if (guard >= 20000) checkOutput({name, "_timeout"}, 96'(1), 96'(0));
        @(negedge clk);
        checkOutput({name, "_ready_fell"}, 96'(s_ready), 96'(0));
        repeat (4) @(negedge clk);

        checkOutput({name, "_ready_cycles"}, 96'(ready_bad), 96'(0));
        checkOutput({name, "_nwrites"}, 96'(obs_wr.size()), 96'(exp_wr.size()));
        foreach (exp_wr[i])
            if (i < obs_wr.size())
                checkOutput($sformatf("%s_wr%0d", name, i), 96'(obs_wr[i]), 96'(exp_wr[i]));
        if (aborted) begin
            checkOutput({name, "_ndone"}, 96'(obs_done.size()), 96'(0));
        end else begin
            checkOutput({name, "_ndone"}, 96'(obs_done.size()), 96'(1));
            if (obs_done.size() > 0)
                checkOutput({name, "_done_cyc"}, 96'(obs_done[0]),
                            96'((rows == 0) ? start_cyc + 2 : last_cyc + 2));
        end
        checkOutput({name, "_err"}, 96'(err), 96'(aborted));
`ifdef BIAS_LOAD_CSUM_EN
        if (!aborted) checkOutput({name, "_csum"}, 96'(csum), 96'(sum));
`endif
    endtask

    initial begin
        $display("[TB] bias_ram_loader bench start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_s_ready", 96'(s_ready), 96'(0));
        checkOutput("rst_wr_en", 96'(wr_en), 96'(0));
        checkOutput("rst_wr_addr", 96'(wr_addr), 96'(0));
        checkOutput("rst_wr_data", 96'(wr_data), 96'(0));
        checkOutput("rst_busy", 96'(busy), 96'(0));
        checkOutput("rst_done", 96'(done), 96'(0));
        checkOutput("rst_err", 96'(err), 96'(0));
`ifdef BIAS_LOAD_CSUM_EN
        checkOutput("rst_csum", 96'(csum), 96'(0));
`endif
        rst_n = 1'b1;

        applyStimulus(AW'(0),   2, 100, -1, 1, "seq2");
        applyStimulus(AW'(511), 2, 100, -1, 0, "wrap");
        applyStimulus(AW'(0),   0, 100, -1, 0, "zero");
        applyStimulus(AW'($urandom), 3, 50, -1, 0, "rand3");
        applyStimulus(AW'(5),   2, 100,  7, 0, "abort");
        applyStimulus(AW'(20),  1, 100, -1, 2, "allones");
        applyStimulus(AW'($urandom), 4, 30, -1, 0, "sparse4");

        // Reset in the middle of a load must clear outputs immediately.
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(3); num_rows = (AW+1)'(3);
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = DW'($urandom);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 96'(busy), 96'(0));
        checkOutput("midrst_ready", 96'(s_ready), 96'(0));
        checkOutput("midrst_wr_en", 96'(wr_en), 96'(0));
        checkOutput("midrst_done", 96'(done), 96'(0));
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(AW'(100), 1, 100, -1, 0, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
